// File: rtl/button_pkg.sv
// Shared push-button constants: bit positions in the 4-bit button vectors and
// the press codes consumed by the downstream button-code register.
package button_pkg;

   localparam int BTN_N = 4;

   localparam int BTN_IDX_U = 0;
   localparam int BTN_IDX_R = 1;
   localparam int BTN_IDX_D = 2;
   localparam int BTN_IDX_L = 3;

   localparam logic [2:0] BTN_CODE_NONE = 3'd0;
   localparam logic [2:0] BTN_CODE_U    = 3'd1;
   localparam logic [2:0] BTN_CODE_R    = 3'd2;
   localparam logic [2:0] BTN_CODE_D    = 3'd3;
   localparam logic [2:0] BTN_CODE_L    = 3'd4;

   // Fixed priority U > R > D > L; lower-priority presses in the same cycle are dropped.
   function automatic logic [2:0] btn_encode(input logic [BTN_N-1:0] press);
      logic [2:0] code;
      code = BTN_CODE_NONE;
      if (press[BTN_IDX_U]) begin
         code = BTN_CODE_U;
      end else if (press[BTN_IDX_R]) begin
         code = BTN_CODE_R;
      end else if (press[BTN_IDX_D]) begin
         code = BTN_CODE_D;
      end else if (press[BTN_IDX_L]) begin
         code = BTN_CODE_L;
      end
      return code;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-flop synchroniser, stable-time counter and registered edge detector.
// Level follows raw after DEBOUNCE_CYCLES+2 edges; pulses one cycle after the level; no backpressure.
module debounce_channel #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 24
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             s1;
   logic             s2;
   logic             stable;
   logic             stable_d;
   logic [CNT_W-1:0] cnt;
   logic             press_r;
   logic             release_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Any cycle agreeing with the accepted level restarts the window, so bounce never accumulates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (s2 == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_MAX) begin
         cnt    <= '0;
         stable <= s2;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_d  <= 1'b0;
         press_r   <= 1'b0;
         release_r <= 1'b0;
      end else begin
         stable_d  <= stable;
         press_r   <= stable & ~stable_d;
         release_r <= ~stable & stable_d;
      end
   end

   assign level         = stable;
   assign press_pulse   = press_r;
   assign release_pulse = release_r;

endmodule

// File: rtl/button_debounce.sv
// Debounces the four board buttons and encodes the highest-priority press.
// press_code/press_valid follow btn_press by one cycle; no backpressure.
module button_debounce
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       BTNU,
   input  logic       BTNR,
   input  logic       BTND,
   input  logic       BTNL,
   output logic [3:0] btn_level,
   output logic [3:0] btn_press,
   output logic [3:0] btn_release,
   output logic [2:0] press_code,
   output logic       press_valid
);

   logic [BTN_N-1:0] raw;
   logic [2:0]       code_r;
   logic             valid_r;

   always_comb begin
      raw            = '0;
      raw[BTN_IDX_U] = BTNU;
      raw[BTN_IDX_R] = BTNR;
      raw[BTN_IDX_D] = BTND;
      raw[BTN_IDX_L] = BTNL;
   end

   for (genvar i = 0; i < BTN_N; i++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .clk           (clk),
         .rst_n         (rst_n),
         .raw           (raw[i]),
         .level         (btn_level[i]),
         .press_pulse   (btn_press[i]),
         .release_pulse (btn_release[i])
      );
   end

   // Code holds until the next press; releases never touch it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_r  <= BTN_CODE_NONE;
         valid_r <= 1'b0;
      end else begin
         valid_r <= |btn_press;
         if (|btn_press) begin
            code_r <= btn_encode(btn_press);
         end
      end
   end

   assign press_code  = code_r;
   assign press_valid = valid_r;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with a 4-cycle window; all expectations are hand-derived.
module tb_button_debounce;

   logic       clk;
   logic       rst_n;
   logic       BTNU;
   logic       BTNR;
   logic       BTND;
   logic       BTNL;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_release;
   logic [2:0] press_code;
   logic       press_valid;

   int n_checks = 0;
   int n_errors = 0;

   button_debounce #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .BTNU        (BTNU),
      .BTNR        (BTNR),
      .BTND        (BTND),
      .BTNL        (BTNL),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .press_code  (press_code),
      .press_valid (press_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, req);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                          input logic [3:0] rel, input logic [2:0] code, input logic vld);
      chk({tag, ".level"},   32'(btn_level),   32'(lvl));
      chk({tag, ".press"},   32'(btn_press),   32'(prs));
      chk({tag, ".release"}, 32'(btn_release), 32'(rel));
      chk({tag, ".code"},    32'(press_code),  32'(code));
      chk({tag, ".valid"},   32'(press_valid), 32'(vld));
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      BTNU = 1'b1; BTNR = 1'b1; BTND = 1'b1; BTNL = 1'b1;
      tick(3);
      chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0);

      // Reset release with BTNU held: level at edge 6, press at 7, code at 8.
      BTNR = 1'b0; BTND = 1'b0; BTNL = 1'b0; BTNU = 1'b1;
      rst_n = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         tick(1);
         chk_all($sformatf("up_e%0d", e), 4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0);
      end
      tick(1); chk_all("up_e6", 4'b0001, 4'b0000, 4'b0000, 3'd0, 1'b0);
      tick(1); chk_all("up_e7", 4'b0001, 4'b0001, 4'b0000, 3'd0, 1'b0);
      tick(1); chk_all("up_e8", 4'b0001, 4'b0000, 4'b0000, 3'd1, 1'b1);
      tick(1); chk_all("up_e9", 4'b0001, 4'b0000, 4'b0000, 3'd1, 1'b0);
      BTNU = 1'b0;
      tick(5); chk_all("upfall_e5", 4'b0001, 4'b0000, 4'b0000, 3'd1, 1'b0);
      tick(1); chk_all("upfall_e6", 4'b0000, 4'b0000, 4'b0000, 3'd1, 1'b0);
      tick(1); chk_all("upfall_e7", 4'b0000, 4'b0000, 4'b0001, 3'd1, 1'b0);
      tick(1); chk_all("upfall_e8", 4'b0000, 4'b0000, 4'b0000, 3'd1, 1'b0);

      // Bounce on BTNR: 1,0,1,0 then steady 1.
      for (int e = 0; e < 4; e++) begin
         BTNR = (e % 2 == 0) ? 1'b1 : 1'b0;
         tick(1);
         chk_all($sformatf("bounce_t%0d", e), 4'b0000, 4'b0000, 4'b0000, 3'd1, 1'b0);
      end
      BTNR = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         tick(1);
         chk_all($sformatf("bounce_e%0d", e), 4'b0000, 4'b0000, 4'b0000, 3'd1, 1'b0);
      end
      tick(1); chk_all("bounce_e6", 4'b0010, 4'b0000, 4'b0000, 3'd1, 1'b0);
      tick(1); chk_all("bounce_e7", 4'b0010, 4'b0010, 4'b0000, 3'd1, 1'b0);
      tick(1); chk_all("bounce_e8", 4'b0010, 4'b0000, 4'b0000, 3'd2, 1'b1);
      BTNR = 1'b0;
      tick(10); chk_all("bounce_idle", 4'b0000, 4'b0000, 4'b0000, 3'd2, 1'b0);

      // Glitch on BTND for 3 cycles: the longest pulse that must still be rejected.
      BTND = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         if (e == 4) BTND = 1'b0;
         tick(1);
         chk_all($sformatf("glitch_e%0d", e), 4'b0000, 4'b0000, 4'b0000, 3'd2, 1'b0);
      end

      // BTNL press accepted, then release.
      BTNL = 1'b1;
      tick(8); chk_all("left_acc", 4'b1000, 4'b0000, 4'b0000, 3'd4, 1'b1);
      tick(1); chk_all("left_hold", 4'b1000, 4'b0000, 4'b0000, 3'd4, 1'b0);
      BTNL = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         tick(1);
         chk_all($sformatf("left_rel_e%0d", e), 4'b1000, 4'b0000, 4'b0000, 3'd4, 1'b0);
      end
      tick(1); chk_all("left_rel_e6", 4'b0000, 4'b0000, 4'b0000, 3'd4, 1'b0);
      tick(1); chk_all("left_rel_e7", 4'b0000, 4'b0000, 4'b1000, 3'd4, 1'b0);
      tick(1); chk_all("left_rel_e8", 4'b0000, 4'b0000, 4'b0000, 3'd4, 1'b0);

      // Simultaneous U, D, L: U wins the code, all three pulse.
      BTNU = 1'b1; BTND = 1'b1; BTNL = 1'b1;
      tick(6); chk_all("simul_e6", 4'b1101, 4'b0000, 4'b0000, 3'd4, 1'b0);
      tick(1); chk_all("simul_e7", 4'b1101, 4'b1101, 4'b0000, 3'd4, 1'b0);
      tick(1); chk_all("simul_e8", 4'b1101, 4'b0000, 4'b0000, 3'd1, 1'b1);
      tick(1); chk_all("simul_e9", 4'b1101, 4'b0000, 4'b0000, 3'd1, 1'b0);
      BTNU = 1'b0; BTND = 1'b0; BTNL = 1'b0;
      tick(6); chk_all("simul_rel_e6", 4'b0000, 4'b0000, 4'b0000, 3'd1, 1'b0);
      tick(1); chk_all("simul_rel_e7", 4'b0000, 4'b0000, 4'b1101, 3'd1, 1'b0);
      tick(3); chk_all("simul_idle", 4'b0000, 4'b0000, 4'b0000, 3'd1, 1'b0);

      // Reset in the middle of a BTNR count.
      BTNR = 1'b1;
      tick(3); chk_all("midrst_pre", 4'b0000, 4'b0000, 4'b0000, 3'd1, 1'b0);
      rst_n = 1'b0;
      #1; chk_all("midrst_async", 4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0);
      tick(1);
      rst_n = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         tick(1);
         chk_all($sformatf("midrst_e%0d", e), 4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0);
      end
      tick(1); chk_all("midrst_e6", 4'b0010, 4'b0000, 4'b0000, 3'd0, 1'b0);
      tick(1); chk_all("midrst_e7", 4'b0010, 4'b0010, 4'b0000, 3'd0, 1'b0);
      tick(1); chk_all("midrst_e8", 4'b0010, 4'b0000, 4'b0000, 3'd2, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Front-end conditioning stage for the four board push-buttons (BTNU, BTNR, BTND, BTNL).
- Synchronises each raw pad input to clk and filters contact bounce with a per-button stable-time counter.
- Emits clean levels, one-cycle press/release pulses and an encoded press event.
- Sits directly upstream of the button-code register, which consumes btn_level and the press pulses instead of raw pads.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a new level (10 ms at 100 MHz); legal range 2..2^24-1
- CNT_W, 24, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
- clk  input  1  system clock; single clock domain
- rst_n  input  1  asynchronous active-low reset
- BTNU  input  1  raw up button, asynchronous
- BTNR  input  1  raw right button, asynchronous
- BTND  input  1  raw down button, asynchronous
- BTNL  input  1  raw left button, asynchronous
- btn_level  output  4  debounced levels {L,D,R,U}
- btn_press  output  4  one-cycle pulse per button on accepted 0->1
- btn_release  output  4  one-cycle pulse per button on accepted 1->0
- press_code  output  3  code of last accepted press: 1=U, 2=R, 3=D, 4=L, 0=none since reset
- press_valid  output  1  one-cycle pulse when press_code updates

Behaviour:
- Reset:
  - Single clock; rst_n asynchronous assert, synchronous deassert is the board's concern.
  - While rst_n=0, all flops and all outputs are 0.
  - Reset mid-debounce discards the partial count; no pulse is emitted.
- Synchroniser:
  - Each BTNx passes through a 2-flop synchroniser (s1, s2) reset to 0.
  - Only s2 is used downstream.
- Per-channel counter:
  - cnt is CNT_W bits; stable holds the accepted level.
  - If s2 == stable: cnt <= 0.
  - Else: cnt <= cnt+1. When cnt == DEBOUNCE_CYCLES-1 on that edge, stable <= s2 and cnt <= 0.
  - Any cycle with s2 == stable clears cnt, so a bounce restarts the window.
  - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap is possible.
- Latency:
  - A raw change held steady is captured by s2 two edges after the raw change.
  - btn_level changes DEBOUNCE_CYCLES edges after s2 first differs, for DEBOUNCE_CYCLES+2 edges total.
  - A glitch shorter than DEBOUNCE_CYCLES s2-cycles produces no output change.
- Pulses:
  - btn_press[i] is high for exactly the one cycle in which stable[i] has just gone 0->1 (registered compare of stable against its previous value).
  - btn_release[i] behaves the same on 1->0.
  - Pulses are one cycle after btn_level changes. Each pulse lasts one cycle regardless of hold time.
- Encoder:
  - When any btn_press bit is set, register press_code and assert press_valid the next cycle (one cycle after btn_press).
  - Simultaneous presses are resolved by fixed priority U > R > D > L; lower-priority presses in the same cycle are dropped from the code but still appear in btn_press.
  - press_code holds its value until the next accepted press. Releases never change it.
- Channels are fully independent; simultaneous events on different buttons are processed in parallel.

Decomposition:
- Shared package button_pkg:
  - code constants BTN_CODE_NONE=0, BTN_CODE_U=1, BTN_CODE_R=2, BTN_CODE_D=3, BTN_CODE_L=4
  - bit indices BTN_IDX_U=0, BTN_IDX_R=1, BTN_IDX_D=2, BTN_IDX_L=3
  - the downstream button-code register uses the same constants
- One natural sub-module, debounce_channel: synchroniser, counter and edge detector for a single button, instantiated four times.
- The top level adds the priority encoder and press_valid register.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset: hold rst_n=0 with all BTNx=1 → all outputs 0. Release reset and hold BTNU=1 → btn_level[0] rises 6 edges after release, btn_press[0] one cycle later, press_code=1 with press_valid one further cycle later.
- Bounce: BTNR toggles 1,0,1,0 on successive cycles, then stays 1 → no btn_press[1] during toggling; btn_level[1] rises 6 edges after the final 0->1; press_code=2.
- Glitch: BTND=1 for 3 cycles, then 0 → btn_level, btn_press and press_valid stay 0 throughout.
- Release: BTNL held 1 until accepted (press_code=4), then 0 → btn_release[3] pulses once 7 edges after the fall; press_code remains 4; press_valid stays 0.
- Simultaneous: BTNU, BTND and BTNL rise on the same edge → btn_press=4'b1101 for one cycle, press_code=1, press_valid one pulse.
- Reset mid-count: BTNR=1 for 3 cycles, pulse rst_n low for 1 cycle while BTNR stays 1 → count restarts; btn_level[1] rises 6 edges after rst_n returns high.
